// File: rtl/cpu_datapath_mc_pkg.sv
// Shared definitions for the multicycle datapath: result-source codes,
// functional-unit opcodes and the FSM state encoding.
// Ports: none (package).
package cpu_pkg;

  // Result source select
  localparam logic [1:0] SRC_F   = 2'd0;
  localparam logic [1:0] SRC_PC  = 2'd1;
  localparam logic [1:0] SRC_RAM = 2'd2;
  localparam logic [1:0] SRC_IMM = 2'd3;

  // Functional-unit opcodes
  localparam logic [2:0] FS_PASS = 3'd0;  // A
  localparam logic [2:0] FS_ADD  = 3'd1;  // A + B
  localparam logic [2:0] FS_SUB  = 3'd2;  // A - B
  localparam logic [2:0] FS_AND  = 3'd3;  // A & B
  localparam logic [2:0] FS_OR   = 3'd4;  // A | B
  localparam logic [2:0] FS_XOR  = 3'd5;  // A ^ B
  localparam logic [2:0] FS_NOT  = 3'd6;  // ~A
  localparam logic [2:0] FS_SHL  = 3'd7;  // A << 1

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MEM  = 2'd2,
    ST_WB   = 2'd3
  } state_t;

endpackage

// File: rtl/cpu_datapath_mc_fu.sv
// BUS_W-wide functional unit: purely combinational, result wraps modulo
// 2^BUS_W and there is no carry out.
// Ports: fs (opcode), a/b (operands) -> f (result).
module functional_unit_w
  import cpu_pkg::*;
#(
  parameter int BUS_W = 16,
  parameter int FS_W  = 3
) (
  input  logic [FS_W-1:0]  fs,
  input  logic [BUS_W-1:0] a,
  input  logic [BUS_W-1:0] b,
  output logic [BUS_W-1:0] f
);

  always_comb begin
    f = '0;
    case (fs)
      FS_W'(FS_PASS): f = a;
      FS_W'(FS_ADD):  f = a + b;
      FS_W'(FS_SUB):  f = a - b;
      FS_W'(FS_AND):  f = a & b;
      FS_W'(FS_OR):   f = a | b;
      FS_W'(FS_XOR):  f = a ^ b;
      FS_W'(FS_NOT):  f = ~a;
      FS_W'(FS_SHL):  f = a << 1;
      default:        f = '0;
    endcase
  end

endmodule

// File: rtl/cpu_datapath_mc_reg_file.sv
// Register file: NUM_REGS x BUS_W, three asynchronous read ports (A, B, D),
// one synchronous write port, asynchronous active-low clear of every entry.
// Ports: clk, reset, we/wa/wd (write), ra/rb/rd -> a/b/d (reads).
module reg_file_p #(
  parameter  int BUS_W    = 16,
  parameter  int NUM_REGS = 16,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [BUS_W-1:0]  wd,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic [ADDR_W-1:0] rd,
  output logic [BUS_W-1:0]  a,
  output logic [BUS_W-1:0]  b,
  output logic [BUS_W-1:0]  d
);

  logic [BUS_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  assign a = regs[ra];
  assign b = regs[rb];
  assign d = regs[rd];

endmodule

// File: rtl/cpu_datapath_mc.sv
// Multicycle CPU datapath: one micro-op per start pulse through
// IDLE -> EXEC -> [MEM] -> WB, with a req/ack data-memory port.
// Ports: control fields (DA/AA/BA/FS/MB/SRC/RW/MW/PC, start), memory
// (mem_req/we/addr/wdata/rdata/ack), status (busy/done/zero/neg), reads (Dout/Aout).
module cpu_datapath_mc
  import cpu_pkg::*;
#(
  parameter  int BUS_W      = 16,
  parameter  int NUM_REGS   = 16,
  parameter  int MEM_ADDR_W = 6,
  parameter  int FS_W       = 3,
  localparam int ADDR_W     = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     DA,
  input  logic [ADDR_W-1:0]     AA,
  input  logic [ADDR_W-1:0]     BA,
  input  logic [FS_W-1:0]       FS,
  input  logic                  MB,
  input  logic [1:0]            SRC,
  input  logic                  RW,
  input  logic                  MW,
  input  logic [BUS_W-1:0]      PC,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [BUS_W-1:0]      mem_wdata,
  input  logic [BUS_W-1:0]      mem_rdata,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic                  done,
  output logic                  zero,
  output logic                  neg,
  output logic [BUS_W-1:0]      Dout,
  output logic [BUS_W-1:0]      Aout
);

  state_t state_q, state_d;

  // Micro-op fields latched at the IDLE->EXEC edge
  logic [ADDR_W-1:0] da_q, aa_q, ba_q;
  logic [FS_W-1:0]   fs_q;
  logic              mb_q, rw_q, mw_q;
  logic [1:0]        src_q;
  logic [BUS_W-1:0]  pc_q;

  logic [BUS_W-1:0]  f_q, rdata_q;
  logic [BUS_W-1:0]  a_rd, b_rd, b_op, f, result;
  logic [ADDR_W-1:0] ra;
  logic              reg_we;

  // Port A serves the operand during EXEC and Aout otherwise; only in EXEC
  // does Aout follow the latched source rather than the live AA input.
  assign ra = (state_q == ST_EXEC) ? aa_q : AA;
  assign Aout = a_rd;

  reg_file_p #(.BUS_W(BUS_W), .NUM_REGS(NUM_REGS)) u_rf (
    .clk  (clk),
    .reset(reset),
    .we   (reg_we),
    .wa   (da_q),
    .wd   (result),
    .ra   (ra),
    .rb   (ba_q),
    .rd   (DA),
    .a    (a_rd),
    .b    (b_rd),
    .d    (Dout)
  );

  assign b_op = mb_q ? BUS_W'(ba_q) : b_rd;

  functional_unit_w #(.BUS_W(BUS_W), .FS_W(FS_W)) u_fu (
    .fs(fs_q),
    .a (a_rd),
    .b (b_op),
    .f (f)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and state-decoded outputs; mem_req is decoded from the
  // state so it falls the instant reset is asserted.
  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    done    = 1'b0;
    mem_req = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_d = ST_EXEC;
      end
      ST_EXEC: state_d = (mw_q || src_q == SRC_RAM) ? ST_MEM : ST_WB;
      ST_MEM: begin
        mem_req = 1'b1;
        if (mem_ack) state_d = ST_WB;
      end
      ST_WB: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Field latches, F/flag registers, memory address/data latches, read capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      da_q      <= '0;
      aa_q      <= '0;
      ba_q      <= '0;
      fs_q      <= '0;
      mb_q      <= 1'b0;
      src_q     <= SRC_F;
      rw_q      <= 1'b0;
      mw_q      <= 1'b0;
      pc_q      <= '0;
      f_q       <= '0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            da_q  <= DA;
            aa_q  <= AA;
            ba_q  <= BA;
            fs_q  <= FS;
            mb_q  <= MB;
            src_q <= SRC;
            rw_q  <= RW;
            mw_q  <= MW;
            pc_q  <= PC;
          end
        end
        ST_EXEC: begin
          f_q       <= f;
          zero      <= (f == '0);
          neg       <= f[BUS_W-1];
          mem_addr  <= a_rd[MEM_ADDR_W-1:0];
          mem_wdata <= b_rd;
          mem_we    <= mw_q;
        end
        ST_MEM: begin
          if (mem_ack) rdata_q <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Result mux; the immediate is {AA,BA} sign-extended to the bus width
  always_comb begin
    result = f_q;
    case (src_q)
      SRC_F:   result = f_q;
      SRC_PC:  result = pc_q;
      SRC_RAM: result = rdata_q;
      SRC_IMM: result = BUS_W'($signed({aa_q, ba_q}));
      default: result = f_q;
    endcase
  end

  // The write lands on the WB->IDLE edge
  assign reg_we = done && rw_q;

endmodule
